// File: rtl/proc_pkg.sv
// Shared processor datapath constants and types used by decode, writeback
// and the register file.
package proc_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_REGS       = 32;
    localparam int BYTES_PER_WORD = XLEN / 8;
    localparam int REG_AW         = $clog2(NUM_REGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bus: one strobed write port and two read ports.
// master = decode/writeback side, slave = the register file.
interface reg_file_if
    import proc_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int DEPTH = NUM_REGS,
    parameter int AW    = $clog2(DEPTH)
);

    logic            we;
    logic [AW-1:0]   waddr;
    logic [N/8-1:0]  wstrb;
    logic [N-1:0]    wdata;
    logic [AW-1:0]   raddr_a;
    logic [N-1:0]    rdata_a;
    logic [AW-1:0]   raddr_b;
    logic [N-1:0]    rdata_b;

    modport master (
        output we, waddr, wstrb, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wstrb, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );

endinterface

// File: rtl/rf_entry.sv
// One register file row: synchronous clear, byte-strobed load, and
// per-byte hold for bytes whose strobe is low.
module rf_entry #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic [N/8-1:0] wstrb,
    input  logic [N-1:0]   wdata,
    output logic [N-1:0]   q
);

    // Clear has priority over load; unstrobed bytes keep their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            for (int k = 0; k < N/8; k++) begin
                if (wstrb[k]) begin
                    q[8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Parametrised register file: DEPTH words of N bits, two combinational
// read ports, one byte-strobed synchronous write port, optional
// hardwired-zero entry 0 (ZERO_REG).
// Build option: define RF_BYPASS_EN for write-first reads (the write in
// flight is merged onto a matching read port in the same cycle); leave it
// undefined for read-first behaviour.
module reg_file
    import proc_pkg::*;
#(
    parameter int N        = XLEN,
    parameter int DEPTH    = NUM_REGS,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic      clk,
    input  logic      rst,
    reg_file_if.slave bus
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [N-1:0] rows [DEPTH];
    logic [N-1:0] rd_a;
    logic [N-1:0] rd_b;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_row
            if (ZERO_REG != 0 && i == 0) begin : g_zero
                assign rows[i] = '0;
            end else begin : g_store
                logic ld;
                // Exact address match: addresses >= DEPTH never select a row.
                assign ld = bus.we && (bus.waddr == AW'(i));
                rf_entry #(.N(N)) u_entry (
                    .clk   (clk),
                    .rst   (rst),
                    .ld    (ld),
                    .wstrb (bus.wstrb),
                    .wdata (bus.wdata),
                    .q     (rows[i])
                );
            end
        end
    endgenerate

`ifdef RF_BYPASS_EN
    logic wr_in_range;
    logic wr_zeroed;
    logic byp_a;
    logic byp_b;

    // Stored bytes where the strobe is low, incoming bytes where it is high.
    function automatic logic [N-1:0] byte_merge(input logic [N-1:0]   cur,
                                                input logic [N-1:0]   wd,
                                                input logic [N/8-1:0] st);
        logic [N-1:0] res;
        res = cur;
        for (int k = 0; k < N/8; k++) begin
            if (st[k]) begin
                res[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign wr_in_range = ({1'b0, bus.waddr} < DEPTH_W);
    assign wr_zeroed   = (ZERO_REG != 0) && (bus.waddr == '0);
    assign byp_a = !rst && bus.we && wr_in_range && !wr_zeroed && (bus.raddr_a == bus.waddr);
    assign byp_b = !rst && bus.we && wr_in_range && !wr_zeroed && (bus.raddr_b == bus.waddr);
`endif

    // Read port A: stored word, zero when out of range, optional forwarding.
    always_comb begin
        rd_a = '0;
        if ({1'b0, bus.raddr_a} < DEPTH_W) begin
            rd_a = rows[bus.raddr_a];
        end
`ifdef RF_BYPASS_EN
        if (byp_a) begin
            rd_a = byte_merge(rd_a, bus.wdata, bus.wstrb);
        end
`endif
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_b = '0;
        if ({1'b0, bus.raddr_b} < DEPTH_W) begin
            rd_b = rows[bus.raddr_b];
        end
`ifdef RF_BYPASS_EN
        if (byp_b) begin
            rd_b = byte_merge(rd_b, bus.wdata, bus.wstrb);
        end
`endif
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: dut_a is 32x32 with a zeroed entry 0,
// dut_b is 24x32 with a writable entry 0 and unused upper addresses.
module tb_reg_file;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_if #(.N(32), .DEPTH(32)) ifa ();
    reg_file_if #(.N(32), .DEPTH(24)) ifb ();

    reg_file #(.N(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    reg_file #(.N(32), .DEPTH(24), .ZERO_REG(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        logic [31:0] ea;
        logic [31:0] eb;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] FWD_SAME = 32'h0000_5678;
`else
    localparam logic [31:0] FWD_SAME = 32'h0000_AAAA;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input bit sel, input logic [4:0] addr,
                          input logic [3:0] strb, input logic [31:0] data);
        if (sel) begin
            ifb.we = 1'b1; ifb.waddr = addr; ifb.wstrb = strb; ifb.wdata = data;
        end else begin
            ifa.we = 1'b1; ifa.waddr = addr; ifa.wstrb = strb; ifa.wdata = data;
        end
    endtask

    task automatic clr_wr(input bit sel);
        if (sel) ifb.we = 1'b0;
        else     ifa.we = 1'b0;
    endtask

    // Drive the read addresses and queue the values expected this cycle.
    task automatic expect_rd(input bit sel, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [31:0] ea, input logic [31:0] eb, input string name);
        exp_t e;
        if (sel) begin
            ifb.raddr_a = ra; ifb.raddr_b = rb;
        end else begin
            ifa.raddr_a = ra; ifa.raddr_b = rb;
        end
        e.cyc = cyc; e.sel = sel; e.ea = ea; e.eb = eb; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare both read ports mid-cycle against queued expectations.
    exp_t        m;
    logic [31:0] act_a;
    logic [31:0] act_b;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m = sb.pop_front();
            act_a = m.sel ? ifb.rdata_a : ifa.rdata_a;
            act_b = m.sel ? ifb.rdata_b : ifa.rdata_b;
            checks += 2;
            if (m.cyc != cyc) begin
                errors += 2;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", m.name, cyc, m.cyc);
            end else begin
                if (act_a !== m.ea) begin
                    errors++;
                    $display("FAIL %s port A (dut_%s): got %h required %h",
                             m.name, m.sel ? "b" : "a", act_a, m.ea);
                end
                if (act_b !== m.eb) begin
                    errors++;
                    $display("FAIL %s port B (dut_%s): got %h required %h",
                             m.name, m.sel ? "b" : "a", act_b, m.eb);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifa.we = 1'b0; ifa.waddr = '0; ifa.wstrb = '0; ifa.wdata = '0;
        ifa.raddr_a = '0; ifa.raddr_b = '0;
        ifb.we = 1'b0; ifb.waddr = '0; ifb.wstrb = '0; ifb.wdata = '0;
        ifb.raddr_a = '0; ifb.raddr_b = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        expect_rd(0, 5'd0, 5'd1, 32'h0, 32'h0, "reset_a");
        expect_rd(1, 5'd5, 5'd23, 32'h0, 32'h0, "reset_b");
        step();

        // Fill, then clear with a one-cycle reset
        for (int i = 1; i < 32; i++) begin
            set_wr(0, 5'(i), 4'hF, 32'hDEAD_BEEF);
            step();
        end
        clr_wr(0);
        expect_rd(0, 5'd1, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "fill");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_rd(0, 5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_clear");
            step();
        end

        // Byte strobes
        set_wr(0, 5'd5, 4'b1111, 32'h1122_3344);
        step();
        set_wr(0, 5'd5, 4'b0101, 32'hAABB_CCDD);
        step();
        clr_wr(0);
        expect_rd(0, 5'd5, 5'd5, 32'h11BB_33DD, 32'h11BB_33DD, "byte_strobe");
        step();

        // Zero register vs writable entry 0
        set_wr(0, 5'd0, 4'hF, 32'hFFFF_FFFF);
        set_wr(1, 5'd0, 4'hF, 32'hFFFF_FFFF);
        expect_rd(0, 5'd0, 5'd0, 32'h0, 32'h0, "zero_wcycle");
        step();
        clr_wr(0);
        clr_wr(1);
        expect_rd(0, 5'd0, 5'd5, 32'h0, 32'h11BB_33DD, "zero_reg");
        expect_rd(1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "no_zero_reg");
        step();

        // Null write
        set_wr(0, 5'd5, 4'b0000, 32'h0);
        expect_rd(0, 5'd5, 5'd5, 32'h11BB_33DD, 32'h11BB_33DD, "null_wcycle");
        step();
        clr_wr(0);
        expect_rd(0, 5'd5, 5'd5, 32'h11BB_33DD, 32'h11BB_33DD, "null_write");
        step();

        // Same-cycle read/write on both ports
        set_wr(0, 5'd7, 4'hF, 32'h0000_AAAA);
        step();
        set_wr(0, 5'd7, 4'b0011, 32'h1234_5678);
        expect_rd(0, 5'd7, 5'd7, FWD_SAME, FWD_SAME, "fwd_same_cycle");
        step();
        clr_wr(0);
        expect_rd(0, 5'd7, 5'd7, 32'h0000_5678, 32'h0000_5678, "fwd_next_cycle");
        step();

        // Reset priority over a simultaneous write
        rst = 1'b1;
        set_wr(0, 5'd3, 4'hF, 32'h5555_5555);
        expect_rd(0, 5'd3, 5'd3, 32'h0, 32'h0, "rst_pri_wcycle");
        step();
        rst = 1'b0;
        clr_wr(0);
        expect_rd(0, 5'd3, 5'd7, 32'h0, 32'h0, "rst_pri");
        step();
        expect_rd(0, 5'd5, 5'd0, 32'h0, 32'h0, "rst_midstream");
        step();

        // Out-of-range write on the 24-entry instance
        for (int i = 0; i < 24; i++) begin
            set_wr(1, 5'(i), 4'hF, 32'(i + 1) * 32'h0101_0101);
            step();
        end
        set_wr(1, 5'd28, 4'hF, 32'hCAFE_F00D);
        expect_rd(1, 5'd28, 5'd28, 32'h0, 32'h0, "oor_wcycle");
        step();
        clr_wr(1);
        expect_rd(1, 5'd28, 5'd28, 32'h0, 32'h0, "oor_read");
        step();
        for (int i = 0; i < 24; i++) begin
            expect_rd(1, 5'(i), 5'(24 + (i % 8)), 32'(i + 1) * 32'h0101_0101, 32'h0, "oor_keep");
            step();
        end

        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port register file for the processor datapath. It generalises the single load-enabled register into a bank of DEPTH words, each N bits wide, with:
- two combinational read ports
- one synchronous write port with per-byte write strobes
- optional hardwired-zero entry 0
- optional same-cycle write-to-read forwarding

It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- N, 32, word width in bits; must be a multiple of 8
- DEPTH, 32, number of entries; need not be a power of two
- AW, $clog2(DEPTH), address width (derived; do not override)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high; clears every entry
- we  input  1  write enable
- waddr  input  AW  write address
- wstrb  input  N/8  byte write strobes; bit k enables byte wdata[8k+7:8k]
- wdata  input  N  write data
- raddr_a  input  AW  read address, port A
- rdata_a  output  N  read data, port A
- raddr_b  input  AW  read address, port B
- rdata_b  output  N  read data, port B

## Operation
- **Storage:** DEPTH x N bits. No state machine; the state is the storage contents.
- **Write:** on a rising clk edge with rst=0, we=1 and waddr<DEPTH, each byte k of entry waddr takes wdata byte k where wstrb[k]=1. Other bytes keep their value.
- **Null write:** we=1 with wstrb=0 is a no-op.
- **Out-of-range write:** waddr>=DEPTH is ignored, with no aliasing.
- **Entry 0 with ZERO_REG=1:** writes to entry 0 are discarded, and reads of entry 0 return 0 regardless of the bypass setting.
- **Read:** rdata_x = entry[raddr_x], purely combinational from address to data. raddr_x>=DEPTH returns 0.
- **Dual read:** both ports may read the same address in the same cycle. Each port returns the identical value.
- **Reset:** rst=1 at a rising edge clears all entries to 0. A write presented in the same cycle is dropped; reset has priority.
- **Reset mid-stream:** writes in the cycles before a reset are lost after the reset edge. There is no partial-clear state.

## Timing
- **Write latency:** 1 cycle. Data written at edge t is visible on the read ports from just after edge t.
- **Read latency:** 0 cycles (combinational). Read-to-write ordering within a cycle depends on RF_BYPASS_EN (see Configuration).
- **Output reset value:** after the first reset edge, rdata_a = rdata_b = 0 for every address, until the first write.
- **Before first reset:** contents are undefined in simulation (X).
- **Combinational paths:**
  - raddr_x -> rdata_x
  - we/waddr/wstrb/wdata -> rdata_x, only when bypass is compiled in
- **Sequential vs. combinational:** no internal pipelining; every read-port path is combinational from its inputs.

## Configuration
- Macro RF_BYPASS_EN.
- **Defined (write-first):** when rst=0, we=1, waddr<DEPTH, raddr_x==waddr, and the address is not a zeroed entry 0:
  - rdata_x shows the merged value in the same cycle: wdata bytes where wstrb=1, stored bytes elsewhere.
  - Bypass is suppressed while rst=1; the port returns stored data.
- **Undefined (read-first):** rdata_x always returns the stored value, i.e. pre-write data in the write cycle.
- **Unchanged:** all other behaviour is identical in both builds.

## Structure
- Shared package proc_pkg:
  - XLEN (32) default width
  - NUM_REGS (32) default depth
  - BYTES_PER_WORD derived constant
  - the reg_addr_t typedef used by decode and writeback
- Sub-module rf_entry: one N-bit row with synchronous clear, byte-strobed load, and per-byte hold. It is instantiated DEPTH times (entry 0 omitted or tied to 0 when ZERO_REG=1).
- Top-level reg_file contains:
  - write-address decode
  - the two read muxes
  - optional bypass merge logic under RF_BYPASS_EN

## Test plan
- **Reset clear:** write 0xDEADBEEF to entries 1..31, assert rst one cycle -> every address reads 0x00000000 on both ports.
- **Byte strobes:**
  - write 0x11223344 to entry 5 (wstrb=1111)
  - next cycle write 0xAABBCCDD with wstrb=0101
  - -> entry 5 reads 0x11BB33DD.
- **Zero register:** ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> rdata_a(0)=0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- **Same-cycle read/write:**
  - entry 7 holds 0x0000AAAA
  - write 0x12345678 to entry 7 with wstrb=0011 while raddr_a=raddr_b=7
  - -> with RF_BYPASS_EN, 0x00005678 that cycle; without it, 0x0000AAAA that cycle
  - -> in both builds, 0x00005678 next cycle.
- **Reset priority:** rst=1 and we=1 (entry 3, 0x55555555) in the same cycle -> entry 3 reads 0 afterwards, and bypass output is 0 during that cycle.
- **Out-of-range:**
  - DEPTH=24
  - write 0xCAFEF00D to address 28 -> no entry changes
  - raddr_a=28 reads 0
  - entries 0..23 unchanged.
